bridge_arbiter: RTL and testbench
=================================

Name: bridge_arbiter

Overview:
- Two-master arbiter in front of the system bridge. Master 0 is the CPU data port; master 1 is the DMA/debug port.
- Serialises every device access onto the single PrAddr/PrWD/PrWE/PrRD port.
- Uses round-robin priority, holds the port for a programmable device latency, and returns a one-cycle Ack with read data to the winning master.

Parameters:
- ACCESS_CYCLES, 1, number of cycles the bridge port is held per transaction (device read latency). Legal range is 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- M0_Req  in  1  master 0 transaction request, level
- M0_Addr  in  32  master 0 byte address
- M0_WD  in  32  master 0 write data
- M0_WE  in  1  master 0 write enable (0 = read)
- M0_RD  out  32  master 0 read data, registered
- M0_Ack  out  1  master 0 transaction complete, one-cycle pulse
- M1_Req, M1_Addr, M1_WD, M1_WE, M1_RD, M1_Ack  as for M0, for master 1
- PrAddr  out  32  address to bridge
- PrWD  out  32  write data to bridge
- PrWE  out  1  write enable to bridge
- PrRD  in  32  read data from bridge
- Grant  out  2  one-hot owner of the port (00 = none)
- Busy  out  1  high in ACCESS and RESP

Behaviour:
- Only clock is clk; reset is synchronous and active-high.
- Reset values:
  - state = IDLE
  - all outputs = 0
  - last_grant = 1, so M0 wins the first contention
  - internal counter = 0
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - PrAddr/PrWD/PrWE = 0; Grant = 00.
  - If any Req is high at the clock edge, choose a winner:
    - only one requester: that master wins;
    - both requesters: the master != last_grant wins.
  - On choosing a winner: latch its Addr/WD/WE into internal registers, load counter = ACCESS_CYCLES-1, go to ACCESS.
- ACCESS:
  - Grant = winner one-hot; PrAddr/PrWD = latched values.
  - PrWE = latched WE during the first ACCESS cycle only. Exactly one write pulse per transaction, whatever ACCESS_CYCLES is.
  - Counter decrements each cycle. In the cycle where the counter is 0:
    - if the latched WE is 0, capture PrRD into the winner's RD register;
    - go to RESP.
- RESP:
  - Winner's Ack = 1 for exactly this cycle; Grant stays on the winner.
  - Pr* outputs = 0.
  - last_grant <= winner; next state IDLE.
- Latency: Req first sampled in IDLE at cycle k -> ACCESS in cycles k+1..k+ACCESS_CYCLES -> Ack in cycle k+1+ACCESS_CYCLES.
- Minimum back-to-back spacing is ACCESS_CYCLES+2 cycles, because of one IDLE arbitration cycle.
- Masters hold Req/Addr/WD/WE until Ack.
  - Request inputs are latched at grant, so later changes have no effect.
  - Dropping Req mid-transaction does not abort it; Ack is still issued.
  - Req still high in the IDLE cycle after Ack counts as a new request.
- M0_RD/M1_RD hold their value until the next read completion for that master. Writes leave RD unchanged.
- The losing master sees no Ack and no RD change; it is served next if it keeps Req high (round-robin, no starvation).
- Reset asserted in any state: state returns to IDLE at that edge and all outputs clear.
  - A pending Ack is dropped.
  - A write already pulsed is not undone.
- No address decoding here: out-of-range addresses pass straight through, and the bridge returns 0.
- Invariants:
  - Grant and the Ack bits are never both-masters-high.
  - PrWE is high only while Grant != 00.

Test Plan:
- ACCESS_CYCLES=1, M0 reads 0x7F00 (PrRD = 0x1234) with Req at cycle 0 -> PrAddr = 0x7F00 in cycle 1, PrWE = 0, M0_Ack in cycle 2, M0_RD = 0x1234 from cycle 3; M1 outputs untouched.
- ACCESS_CYCLES=3, M1 writes 0xAA to 0x7F10 -> PrWE high in cycle 1 only, PrAddr held cycles 1-3, M1_Ack in cycle 4, M1_RD unchanged.
- After reset, M0 and M1 both request continuously -> grant order M0, M1, M0, M1; each master sees an Ack every 2*(ACCESS_CYCLES+2) cycles.
- M1 granted; M0 raises Req mid-ACCESS and M1 drops Req -> M1 still Acked; M0 granted in the following IDLE cycle.
- Reset asserted during ACCESS of an M0 read -> next cycle Grant = 00, Busy = 0, no M0_Ack, M0_RD = 0; a fresh request then completes with normal latency.
- ACCESS_CYCLES=2, M0 read while PrRD changes 0x1 -> 0x2 between cycles 1 and 2 -> M0_RD = 0x2, proving capture in the last ACCESS cycle.

Source files
------------

// File: rtl/bridge_arbiter.sv
// rtl/bridge_arbiter.sv - two-master round-robin arbiter in front of the system bridge port
// Holds the port for ACCESS_CYCLES per transaction and returns a one-cycle Ack with registered read data.
module bridge_arbiter #(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M0_Req,
  input  logic [31:0] M0_Addr,
  input  logic [31:0] M0_WD,
  input  logic        M0_WE,
  output logic [31:0] M0_RD,
  output logic        M0_Ack,
  input  logic        M1_Req,
  input  logic [31:0] M1_Addr,
  input  logic [31:0] M1_WD,
  input  logic        M1_WE,
  output logic [31:0] M1_RD,
  output logic        M1_Ack,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  input  logic [31:0] PrRD,
  output logic [1:0]  Grant,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic        winner;
  logic        last_grant;
  logic        pick;
  logic        any_req;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;
  logic        lat_we;
  logic [3:0]  cnt;
  logic        first_cycle;

  assign any_req     = M0_Req | M1_Req;
  // On contention the master that did not win last time is served.
  assign pick        = (M0_Req && M1_Req) ? ~last_grant : M1_Req;
  assign first_cycle = (cnt == CNT_INIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      winner     <= 1'b0;
      last_grant <= 1'b1;
      lat_addr   <= '0;
      lat_wd     <= '0;
      lat_we     <= 1'b0;
      cnt        <= '0;
      M0_RD      <= '0;
      M1_RD      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner   <= pick;
            lat_addr <= pick ? M1_Addr : M0_Addr;
            lat_wd   <= pick ? M1_WD   : M0_WD;
            lat_we   <= pick ? M1_WE   : M0_WE;
            cnt      <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_we) begin
            if (winner) M1_RD <= PrRD;
            else        M0_RD <= PrRD;
          end
        end
        RESP: last_grant <= winner;
        default: ;
      endcase
    end
  end

  always_comb begin
    PrAddr = '0;
    PrWD   = '0;
    PrWE   = 1'b0;
    Grant  = 2'b00;
    Busy   = 1'b0;
    M0_Ack = 1'b0;
    M1_Ack = 1'b0;
    case (state)
      ACCESS: begin
        Grant  = winner ? 2'b10 : 2'b01;
        PrAddr = lat_addr;
        PrWD   = lat_wd;
        // A single write strobe per transaction regardless of the hold time.
        PrWE   = lat_we && first_cycle;
        Busy   = 1'b1;
      end
      RESP: begin
        Grant  = winner ? 2'b10 : 2'b01;
        Busy   = 1'b1;
        M0_Ack = ~winner;
        M1_Ack = winner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// tb/tb_bridge_arbiter.sv - self-checking bench for bridge_arbiter
// Three instances (ACCESS_CYCLES = 1, 2, 3) share inputs; each scenario targets one instance.
module tb_bridge_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wd;
  logic [1:0]       we;
  logic [31:0]      pr_rd;

  logic [2:0][31:0] m0_rd, m1_rd, pr_addr, pr_wd;
  logic [2:0]       m0_ack, m1_ack, pr_we, busy;
  logic [2:0][1:0]  grant;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bridge_arbiter #(.ACCESS_CYCLES(g + 1)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .M0_Req  (req[0]),
      .M0_Addr (addr[0]),
      .M0_WD   (wd[0]),
      .M0_WE   (we[0]),
      .M0_RD   (m0_rd[g]),
      .M0_Ack  (m0_ack[g]),
      .M1_Req  (req[1]),
      .M1_Addr (addr[1]),
      .M1_WD   (wd[1]),
      .M1_WE   (we[1]),
      .M1_RD   (m1_rd[g]),
      .M1_Ack  (m1_ack[g]),
      .PrAddr  (pr_addr[g]),
      .PrWD    (pr_wd[g]),
      .PrWE    (pr_we[g]),
      .PrRD    (pr_rd),
      .Grant   (grant[g]),
      .Busy    (busy[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    addr  = '0;
    wd    = '0;
    we    = '0;
    pr_rd = '0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic new_txn(input int m);
    addr[m] = $urandom;
    wd[m]   = $urandom;
    we[m]   = 1'($urandom_range(1));
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({m0_rd[d], m1_rd[d], pr_addr[d], pr_wd[d], m0_ack[d], m1_ack[d], pr_we[d], busy[d], grant[d]} !== '0) begin
        fails++;
        $display("FAIL reset_state dut%0d: rd0=%h rd1=%h addr=%h wd=%h ack=%b%b we=%b busy=%b grant=%b, all required 0",
                 d, m0_rd[d], m1_rd[d], pr_addr[d], pr_wd[d], m1_ack[d], m0_ack[d], pr_we[d], busy[d], grant[d]);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    req[0] = 1'b1; addr[0] = 32'h7F00; we[0] = 1'b0; pr_rd = 32'h1234;
    step();
    checks++;
    if ({grant[0], busy[0], pr_we[0], pr_addr[0]} !== {2'b01, 1'b1, 1'b0, 32'h7F00}) begin
      fails++;
      $display("FAIL read_access: got grant=%b busy=%b we=%b addr=%h, required 01 1 0 00007f00",
               grant[0], busy[0], pr_we[0], pr_addr[0]);
    end
    step();
    checks++;
    if ({m0_ack[0], m1_ack[0], grant[0], pr_addr[0]} !== {1'b1, 1'b0, 2'b01, 32'h0}) begin
      fails++;
      $display("FAIL read_ack: got ack0=%b ack1=%b grant=%b addr=%h, required 1 0 01 0",
               m0_ack[0], m1_ack[0], grant[0], pr_addr[0]);
    end
    req[0] = 1'b0;
    step();
    checks++;
    if ({m0_rd[0], m1_rd[0], m0_ack[0], grant[0]} !== {32'h1234, 32'h0, 1'b0, 2'b00}) begin
      fails++;
      $display("FAIL read_data: got rd0=%h rd1=%h ack0=%b grant=%b, required 00001234 0 0 00",
               m0_rd[0], m1_rd[0], m0_ack[0], grant[0]);
    end
  endtask

  task automatic test_write();
    do_reset();
    req[1] = 1'b1; addr[1] = 32'h7F10; wd[1] = 32'hAA; we[1] = 1'b1; pr_rd = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if ({grant[2], pr_we[2], pr_addr[2], pr_wd[2]} !== {2'b10, (c == 1), 32'h7F10, 32'hAA}) begin
        fails++;
        $display("FAIL write_access c%0d: got grant=%b we=%b addr=%h wd=%h, required 10 %0d 00007f10 000000aa",
                 c, grant[2], pr_we[2], pr_addr[2], pr_wd[2], (c == 1));
      end
    end
    step();
    checks++;
    if ({m1_ack[2], m0_ack[2], grant[2], pr_we[2]} !== {1'b1, 1'b0, 2'b10, 1'b0}) begin
      fails++;
      $display("FAIL write_ack: got ack1=%b ack0=%b grant=%b we=%b, required 1 0 10 0",
               m1_ack[2], m0_ack[2], grant[2], pr_we[2]);
    end
    req[1] = 1'b0;
    step();
    checks++;
    if (m1_rd[2] !== 32'h0) begin
      fails++;
      $display("FAIL write_rd_unchanged: got rd1=%h, required 0", m1_rd[2]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ack;
    do_reset();
    req = 2'b11; we = 2'b00;
    for (int c = 0; c < 16; c++) begin
      exp_ack = (c % 4 == 3) ? (((c / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if ({m1_ack[1], m0_ack[1]} !== exp_ack) begin
        fails++;
        $display("FAIL round_robin c%0d: got ack=%b, required %b", c, {m1_ack[1], m0_ack[1]}, exp_ack);
      end
      step();
    end
    req = 2'b00;
  endtask

  task automatic test_mid_change();
    do_reset();
    req[1] = 1'b1; we[1] = 1'b0;
    step();
    req[0] = 1'b1; req[1] = 1'b0;
    step();
    step();
    checks++;
    if ({m1_ack[1], m0_ack[1]} !== 2'b10) begin
      fails++;
      $display("FAIL mid_change_ack: got ack=%b, required 10", {m1_ack[1], m0_ack[1]});
    end
    step();
    step();
    checks++;
    if (grant[1] !== 2'b01) begin
      fails++;
      $display("FAIL mid_change_next_grant: got grant=%b, required 01", grant[1]);
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h7F20; pr_rd = 32'h55;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({grant[2], busy[2], m0_ack[2], m0_rd[2]} !== {2'b00, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_mid: got grant=%b busy=%b ack0=%b rd0=%h, required 00 0 0 0",
               grant[2], busy[2], m0_ack[2], m0_rd[2]);
    end
    for (int c = 4; c <= 7; c++) begin
      step();
      checks++;
      if (m0_ack[2] !== (c == 7)) begin
        fails++;
        $display("FAIL reset_mid_relaunch c%0d: got ack0=%b, required %0d", c, m0_ack[2], (c == 7));
      end
    end
    checks++;
    if (m0_rd[2] !== 32'h55) begin
      fails++;
      $display("FAIL reset_mid_rd: got rd0=%h, required 00000055", m0_rd[2]);
    end
    req = 2'b00;
  endtask

  task automatic test_capture_edge();
    do_reset();
    req[0] = 1'b1; we[0] = 1'b0; pr_rd = 32'h1;
    step();
    step();
    pr_rd = 32'h2;
    step();
    checks++;
    if ({m0_ack[1], m0_rd[1]} !== {1'b1, 32'h2}) begin
      fails++;
      $display("FAIL capture_edge: got ack0=%b rd0=%h, required 1 00000002", m0_ack[1], m0_rd[1]);
    end
    req = 2'b00;
  endtask

  // Transaction-level reference: each grant occupies the port for n cycles, acks one cycle later,
  // and the port re-arbitrates n+2 cycles after the arbitration cycle.
  task automatic test_random(input int d);
    int          n, free_c, start_c, ack_c;
    logic        active, win, last, we_l;
    logic [31:0] addr_l, wd_l, cap, erd0, erd1;
    logic [1:0]  eg, eack;
    logic        ewe, ebusy;
    logic [31:0] eaddr, ewd;
    n = d + 1;
    do_reset();
    active = 1'b0; last = 1'b1; free_c = 0; start_c = 0; ack_c = 0;
    win = 1'b0; we_l = 1'b0; addr_l = '0; wd_l = '0; cap = '0; erd0 = '0; erd1 = '0;
    for (int c = 0; c < 300; c++) begin
      eg = 2'b00; eack = 2'b00; ewe = 1'b0; ebusy = 1'b0; eaddr = '0; ewd = '0;
      if (active && c >= start_c && c < ack_c) begin
        eg = win ? 2'b10 : 2'b01; eaddr = addr_l; ewd = wd_l; ewe = we_l && (c == start_c); ebusy = 1'b1;
      end
      if (active && c == ack_c) begin
        eg = win ? 2'b10 : 2'b01; ebusy = 1'b1; eack = win ? 2'b10 : 2'b01;
        if (!we_l) begin
          if (win) erd1 = cap;
          else     erd0 = cap;
        end
        last = win;
        active = 1'b0;
      end
      checks++;
      if ({grant[d], m1_ack[d], m0_ack[d], pr_we[d], busy[d], pr_addr[d], pr_wd[d], m0_rd[d], m1_rd[d]} !==
          {eg, eack, ewe, ebusy, eaddr, ewd, erd0, erd1}) begin
        fails++;
        $display("FAIL random dut%0d c%0d: got g=%b ack=%b we=%b busy=%b a=%h wd=%h rd0=%h rd1=%h, required g=%b ack=%b we=%b busy=%b a=%h wd=%h rd0=%h rd1=%h",
                 d, c, grant[d], {m1_ack[d], m0_ack[d]}, pr_we[d], busy[d], pr_addr[d], pr_wd[d], m0_rd[d], m1_rd[d],
                 eg, eack, ewe, ebusy, eaddr, ewd, erd0, erd1);
      end
      for (int m = 0; m < 2; m++) begin
        if (req[m]) begin
          if (eack[m]) begin
            if ($urandom_range(1) == 0) req[m] = 1'b0;
            else new_txn(m);
          end
        end else if ($urandom_range(3) == 0) begin
          req[m] = 1'b1;
          new_txn(m);
        end
      end
      pr_rd = $urandom;
      if (active && c == ack_c - 1 && !we_l) cap = pr_rd;
      if (!active && c >= free_c && req != 2'b00) begin
        win     = (req == 2'b11) ? ~last : req[1];
        addr_l  = addr[win];
        wd_l    = wd[win];
        we_l    = we[win];
        active  = 1'b1;
        start_c = c + 1;
        ack_c   = c + 1 + n;
        free_c  = c + n + 2;
      end
      step();
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_mid_change();
    test_reset_mid();
    test_capture_edge();
    for (int d = 0; d < 3; d++) test_random(d);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
